regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file with two read ports, two write ports and an integrated write-pending scoreboard, replacing the single-write-port register file in the pipelined core. The decode stage reads operands and busy status. Issue marks destinations pending. The two writeback ports (ALU and load/mult) commit results and clear pending status. An optional same-cycle write-to-read bypass removes the half-cycle write trick: all writes commit on the rising edge.

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 5, address width; NREG = 2**AW registers
- BYPASS, 1, 1 = same-cycle write data/clear forwarded to read ports; 0 = reads see committed state only
- ZERO_REG, 1, 1 = register 0 hard-wired to zero, never written, never busy

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ra_a  in  AW  read address, port A
- ra_b  in  AW  read address, port B
- rdata_a  out  DW  read data, port A (combinational)
- rdata_b  out  DW  read data, port B (combinational)
- busy_a  out  1  register at ra_a has a pending write
- busy_b  out  1  register at ra_b has a pending write
- we0, we1  in  1  write enables, ports 0/1
- wa0, wa1  in  AW  write addresses
- wd0, wd1  in  DW  write data
- iss_v  in  1  issue: mark register iss_a pending
- iss_a  in  AW  issue destination address
- busy_cnt  out  AW+1  number of registers currently pending (registered)

## Operation
- Storage: NREG x DW data array plus NREG-bit busy vector.
- Write port x with wex=1: data[wax] <= wdx; busy[wax] <= 0.
- Both ports write the same address: port 1 data wins; busy cleared.
- Issue with iss_v=1: busy[iss_a] <= 1.
- Issue and write to the same address in one cycle: data updated, busy ends at 1. The issue is a newer producer and takes precedence over the clear.
- ZERO_REG=1, address 0:
  - writes and issue are ignored;
  - rdata reads 0 and busy reads 0.
- Reads are combinational from the array and busy vector.
- BYPASS=1: if a write enable matches the read address this cycle, rdata returns that write's data (port 1 over port 0) and busy returns 0. Issue is not forwarded; it becomes visible the next cycle.
- BYPASS=0: no forwarding; reads show pre-edge state.
- busy_cnt tracks the popcount of the busy vector. It is updated incrementally each cycle:
  - +1 for an issue to a non-busy register;
  - −1 per distinct busy register cleared;
  - the net change lies in [−2,+1];
  - it never wraps: maximum value NREG (or NREG−1 with ZERO_REG=1).
- Issue to a register that is already busy: busy stays 1, count unchanged. Write to a non-busy register: count unchanged.

## Timing
- Reset (async assert, any cycle, including mid-operation): all data words = 0, busy vector = 0, busy_cnt = 0. Consequently rdata_a/b = 0 and busy_a/b = 0 immediately.
- Reset release: first update on the next rising edge with rst=0.
- Write latency: data is visible on read ports one edge after we (0 cycles with BYPASS=1).
- Issue latency: busy is visible the cycle after iss_v.
- busy_cnt is consistent with the busy vector after the same edge; no extra lag.
- No handshakes. All inputs are sampled every rising edge; there is no backpressure.

## Structure
- Shared package regfile_pkg holds:
  - default DW/AW constants;
  - the reg_addr_t and reg_data_t typedefs;
  - ZERO_ADDR.
- One sub-module is natural: regfile_sb_fwd, the per-read-port bypass/zero mux. It is instantiated twice and is purely combinational.
- The scoreboard, counter and array stay in the top module.

## Test plan
- Reset mid-stream: write r5=0x1234, assert rst asynchronously between edges. Required: rdata(r5)=0, busy_cnt=0 immediately, before the next edge.
- Dual write, same address: we0/we1 both to r7, wd0=0xAAAA0000, wd1=0x5555FFFF. Required: next cycle r7=0x5555FFFF. With BYPASS=1, same-cycle read of r7 also returns 0x5555FFFF.
- Scoreboard:
  - issue r3, r4, r3 on consecutive cycles → busy_cnt 1, 2, 2;
  - write r3 and r4 together → busy_cnt=0, busy_a(r3)=0.
- Issue/clear collision: r9 busy; same cycle iss_a=9 and we0 to r9 with 0xDEAD. Required: r9=0xDEAD, busy(r9)=1, busy_cnt unchanged.
- Zero register (ZERO_REG=1): we0 to r0 with 0xFFFFFFFF plus iss_a=0. Required: rdata(r0)=0, busy(r0)=0, busy_cnt unchanged.
- BYPASS=0 build: write r2=0x42 and read r2 in the same cycle. Required: old value that cycle, 0x42 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and typedefs for the register file
package regfile_pkg;

  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_AW = 5;
  localparam int ZERO_ADDR  = 0;

  typedef logic [DEFAULT_AW-1:0] reg_addr_t;
  typedef logic [DEFAULT_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/write/issue bus between the pipeline and the register file
interface regfile_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic [AW-1:0] ra_a;
  logic [AW-1:0] ra_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          busy_a;
  logic          busy_b;
  logic          we0;
  logic          we1;
  logic [AW-1:0] wa0;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd0;
  logic [DW-1:0] wd1;
  logic          iss_v;
  logic [AW-1:0] iss_a;
  logic [AW:0]   busy_cnt;

  modport master (
    output ra_a, ra_b, we0, we1, wa0, wa1, wd0, wd1, iss_v, iss_a,
    input  rdata_a, rdata_b, busy_a, busy_b, busy_cnt
  );

  modport slave (
    input  ra_a, ra_b, we0, we1, wa0, wa1, wd0, wd1, iss_v, iss_a,
    output rdata_a, rdata_b, busy_a, busy_b, busy_cnt
  );

endinterface

// File: rtl/regfile_sb_fwd.sv
// rtl/regfile_sb_fwd.sv - per-read-port write bypass and zero-register mux
module regfile_sb_fwd
  import regfile_pkg::*;
#(
  parameter int DW       = DEFAULT_DW,
  parameter int AW       = DEFAULT_AW,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] ra_i,
  input  logic [DW-1:0] word_i,
  input  logic          busy_i,
  input  logic          we0_i,
  input  logic [AW-1:0] wa0_i,
  input  logic [DW-1:0] wd0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] wa1_i,
  input  logic [DW-1:0] wd1_i,
  output logic [DW-1:0] rdata_o,
  output logic          busy_o
);

  always_comb begin
    rdata_o = word_i;
    busy_o  = busy_i;
    // Port 1 is checked last so it wins when both ports hit the read address.
    if (BYPASS != 0) begin
      if (we0_i && (wa0_i == ra_i)) begin
        rdata_o = wd0_i;
        busy_o  = 1'b0;
      end
      if (we1_i && (wa1_i == ra_i)) begin
        rdata_o = wd1_i;
        busy_o  = 1'b0;
      end
    end
    if ((ZERO_REG != 0) && (ra_i == AW'(ZERO_ADDR))) begin
      rdata_o = '0;
      busy_o  = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2R/2W register file with write-pending scoreboard and counter
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DW       = DEFAULT_DW,
  parameter int AW       = DEFAULT_AW,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  regfile_sb_if.slave bus
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0]   data_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic we0_eff, we1_eff, iss_eff;
  logic inc, clr0, clr1;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(ZERO_ADDR));
  endfunction

  always_comb begin
    we0_eff = bus.we0 && !is_zero(bus.wa0);
    we1_eff = bus.we1 && !is_zero(bus.wa1);
    iss_eff = bus.iss_v && !is_zero(bus.iss_a);

    // Incremental popcount: a clear overridden by a same-cycle issue does not count,
    // and a dual write to one address clears only once.
    inc  = iss_eff && !busy_q[bus.iss_a];
    clr0 = we0_eff && busy_q[bus.wa0] && !(iss_eff && (bus.iss_a == bus.wa0));
    clr1 = we1_eff && busy_q[bus.wa1] && !(iss_eff && (bus.iss_a == bus.wa1))
           && !(we0_eff && (bus.wa0 == bus.wa1));

    busy_d = busy_q;
    if (we0_eff) busy_d[bus.wa0] = 1'b0;
    if (we1_eff) busy_d[bus.wa1] = 1'b0;
    if (iss_eff) busy_d[bus.iss_a] = 1'b1;

    cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, clr0} - {{AW{1'b0}}, clr1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we0_eff) data_q[bus.wa0] <= bus.wd0;
      if (we1_eff) data_q[bus.wa1] <= bus.wd1;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.busy_cnt = cnt_q;

  regfile_sb_fwd #(.DW(DW), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .ra_i    (bus.ra_a),
    .word_i  (data_q[bus.ra_a]),
    .busy_i  (busy_q[bus.ra_a]),
    .we0_i   (bus.we0),
    .wa0_i   (bus.wa0),
    .wd0_i   (bus.wd0),
    .we1_i   (bus.we1),
    .wa1_i   (bus.wa1),
    .wd1_i   (bus.wd1),
    .rdata_o (bus.rdata_a),
    .busy_o  (bus.busy_a)
  );

  regfile_sb_fwd #(.DW(DW), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .ra_i    (bus.ra_b),
    .word_i  (data_q[bus.ra_b]),
    .busy_i  (busy_q[bus.ra_b]),
    .we0_i   (bus.we0),
    .wa0_i   (bus.wa0),
    .wd0_i   (bus.wd0),
    .we1_i   (bus.we1),
    .wa1_i   (bus.wa1),
    .wd1_i   (bus.wd1),
    .rdata_o (bus.rdata_b),
    .busy_o  (bus.busy_b)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb (bypass and no-bypass builds)
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  regfile_sb_if #(.DW(32), .AW(5)) b1 ();
  regfile_sb_if #(.DW(32), .AW(5)) b0 ();

  regfile_sb #(.DW(32), .AW(5), .BYPASS(1), .ZERO_REG(1)) u_byp (.clk(clk), .rst(rst), .bus(b1));
  regfile_sb #(.DW(32), .AW(5), .BYPASS(0), .ZERO_REG(1)) u_nob (.clk(clk), .rst(rst), .bus(b0));

  assign b0.ra_a  = b1.ra_a;
  assign b0.ra_b  = b1.ra_b;
  assign b0.we0   = b1.we0;
  assign b0.we1   = b1.we1;
  assign b0.wa0   = b1.wa0;
  assign b0.wa1   = b1.wa1;
  assign b0.wd0   = b1.wd0;
  assign b0.wd1   = b1.wd1;
  assign b0.iss_v = b1.iss_v;
  assign b0.iss_a = b1.iss_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    b1.we0 = 0; b1.we1 = 0; b1.wa0 = '0; b1.wa1 = '0;
    b1.wd0 = '0; b1.wd1 = '0; b1.iss_v = 0; b1.iss_a = '0;
  endtask

  task automatic edge_then_idle();
    @(posedge clk); #1;
    idle();
    #1;
  endtask

  task automatic test_reset();
    b1.ra_a = 5'd5; b1.ra_b = 5'd6;
    #1;
    total++; if (b1.rdata_a !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", b1.rdata_a); else passed++;
    total++; if (b1.busy_cnt !== 6'd0) $display("FAIL reset_cnt got=%0d exp=0", b1.busy_cnt); else passed++;
    total++; if (b0.busy_b !== 1'b0) $display("FAIL reset_busy got=%b exp=0", b0.busy_b); else passed++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    b1.we0 = 1; b1.wa0 = 5'd5; b1.wd0 = 32'h1234; b1.iss_v = 1; b1.iss_a = 5'd6;
    edge_then_idle();
    total++; if (b0.rdata_a !== 32'h1234) $display("FAIL mid_write got=%h exp=1234", b0.rdata_a); else passed++;
    total++; if (b1.busy_cnt !== 6'd1) $display("FAIL mid_cnt got=%0d exp=1", b1.busy_cnt); else passed++;
    rst = 1; #1;
    total++; if (b1.rdata_a !== 32'h0) $display("FAIL mid_rst_rdata got=%h exp=0", b1.rdata_a); else passed++;
    total++; if (b0.busy_cnt !== 6'd0) $display("FAIL mid_rst_cnt got=%0d exp=0", b0.busy_cnt); else passed++;
    total++; if (b1.busy_b !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", b1.busy_b); else passed++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    b1.ra_a = 5'd7;
    b1.we0 = 1; b1.wa0 = 5'd7; b1.wd0 = 32'hAAAA0000;
    b1.we1 = 1; b1.wa1 = 5'd7; b1.wd1 = 32'h5555FFFF;
    #1;
    total++; if (b1.rdata_a !== 32'h5555FFFF) $display("FAIL dual_bypass got=%h exp=5555ffff", b1.rdata_a); else passed++;
    total++; if (b0.rdata_a !== 32'h0) $display("FAIL dual_nobypass_old got=%h exp=0", b0.rdata_a); else passed++;
    edge_then_idle();
    total++; if (b0.rdata_a !== 32'h5555FFFF) $display("FAIL dual_commit got=%h exp=5555ffff", b0.rdata_a); else passed++;
  endtask

  task automatic test_scoreboard();
    logic [5:0] exp_cnt [3];
    logic [4:0] iss_seq [3];
    exp_cnt = '{6'd1, 6'd2, 6'd2};
    iss_seq = '{5'd3, 5'd4, 5'd3};
    b1.ra_a = 5'd3; b1.ra_b = 5'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b1.iss_v = 1; b1.iss_a = iss_seq[i];
      edge_then_idle();
      total++; if (b1.busy_cnt !== exp_cnt[i]) $display("FAIL sb_cnt%0d got=%0d exp=%0d", i, b1.busy_cnt, exp_cnt[i]); else passed++;
    end
    total++; if (b1.busy_a !== 1'b1 || b1.busy_b !== 1'b1) $display("FAIL sb_busy got=%b%b exp=11", b1.busy_a, b1.busy_b); else passed++;
    @(negedge clk);
    b1.we0 = 1; b1.wa0 = 5'd3; b1.wd0 = 32'h33;
    b1.we1 = 1; b1.wa1 = 5'd4; b1.wd1 = 32'h44;
    #1;
    total++; if (b1.busy_a !== 1'b0) $display("FAIL sb_fwd_busy got=%b exp=0", b1.busy_a); else passed++;
    total++; if (b0.busy_a !== 1'b1) $display("FAIL sb_nofwd_busy got=%b exp=1", b0.busy_a); else passed++;
    edge_then_idle();
    total++; if (b1.busy_cnt !== 6'd0) $display("FAIL sb_clear_cnt got=%0d exp=0", b1.busy_cnt); else passed++;
    total++; if (b0.busy_a !== 1'b0) $display("FAIL sb_clear_busy got=%b exp=0", b0.busy_a); else passed++;
    total++; if (b0.rdata_b !== 32'h44) $display("FAIL sb_clear_data got=%h exp=44", b0.rdata_b); else passed++;
  endtask

  task automatic test_collision();
    b1.ra_a = 5'd9;
    @(negedge clk);
    b1.iss_v = 1; b1.iss_a = 5'd9;
    edge_then_idle();
    total++; if (b1.busy_cnt !== 6'd1) $display("FAIL col_pre_cnt got=%0d exp=1", b1.busy_cnt); else passed++;
    @(negedge clk);
    b1.iss_v = 1; b1.iss_a = 5'd9; b1.we0 = 1; b1.wa0 = 5'd9; b1.wd0 = 32'hDEAD;
    edge_then_idle();
    total++; if (b0.rdata_a !== 32'hDEAD) $display("FAIL col_data got=%h exp=dead", b0.rdata_a); else passed++;
    total++; if (b1.busy_a !== 1'b1) $display("FAIL col_busy got=%b exp=1", b1.busy_a); else passed++;
    total++; if (b1.busy_cnt !== 6'd1) $display("FAIL col_cnt got=%0d exp=1", b1.busy_cnt); else passed++;
  endtask

  task automatic test_zero_reg();
    b1.ra_a = 5'd0;
    @(negedge clk);
    b1.we0 = 1; b1.wa0 = 5'd0; b1.wd0 = 32'hFFFFFFFF; b1.iss_v = 1; b1.iss_a = 5'd0;
    #1;
    total++; if (b1.rdata_a !== 32'h0) $display("FAIL zero_fwd got=%h exp=0", b1.rdata_a); else passed++;
    edge_then_idle();
    total++; if (b0.rdata_a !== 32'h0) $display("FAIL zero_data got=%h exp=0", b0.rdata_a); else passed++;
    total++; if (b1.busy_a !== 1'b0) $display("FAIL zero_busy got=%b exp=0", b1.busy_a); else passed++;
    total++; if (b1.busy_cnt !== 6'd1) $display("FAIL zero_cnt got=%0d exp=1", b1.busy_cnt); else passed++;
  endtask

  task automatic test_dual_clear_same();
    b1.ra_a = 5'd9;
    @(negedge clk);
    b1.we0 = 1; b1.wa0 = 5'd9; b1.wd0 = 32'h1;
    b1.we1 = 1; b1.wa1 = 5'd9; b1.wd1 = 32'h2;
    edge_then_idle();
    total++; if (b1.busy_cnt !== 6'd0) $display("FAIL dclr_cnt got=%0d exp=0", b1.busy_cnt); else passed++;
    total++; if (b0.rdata_a !== 32'h2) $display("FAIL dclr_data got=%h exp=2", b0.rdata_a); else passed++;
  endtask

  task automatic test_bypass_off();
    b1.ra_b = 5'd2;
    @(negedge clk);
    b1.we1 = 1; b1.wa1 = 5'd2; b1.wd1 = 32'h42;
    #1;
    total++; if (b0.rdata_b !== 32'h0) $display("FAIL nob_same got=%h exp=0", b0.rdata_b); else passed++;
    total++; if (b1.rdata_b !== 32'h42) $display("FAIL byp_same got=%h exp=42", b1.rdata_b); else passed++;
    edge_then_idle();
    total++; if (b0.rdata_b !== 32'h42) $display("FAIL nob_next got=%h exp=42", b0.rdata_b); else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1;
    b1.ra_a = '0; b1.ra_b = '0;
    idle();
    test_reset();
    test_reset_midstream();
    test_dual_write();
    test_scoreboard();
    test_collision();
    test_zero_reg();
    test_dual_clear_same();
    test_bypass_off();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
